// File: rtl/cpu_param.sv
// Parameterised multi-cycle accumulator-style CPU: FETCH/DECODE/EXECUTE with a terminal HALT,
// general register file, two status flags and a small internal data memory.
module cpu_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREGS   = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DMEM_AW = 4,
  localparam int unsigned RSEL_W  = $clog2(NREGS),
  localparam int unsigned INSTR_W = 4 + 2 * RSEL_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]      imem_data,
  output logic [NREGS*DATA_W-1:0] regs_flat,
  output logic [ADDR_W-1:0]       pc,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic                    halted
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpSt   = 4'h4;
  localparam logic [3:0] OpLd   = 4'h5;
  localparam logic [3:0] OpJmp  = 4'h6;
  localparam logic [3:0] OpJz   = 4'h7;
  localparam logic [3:0] OpHalt = 4'h8;

  typedef enum logic [1:0] {StFetch, StDecode, StExecute, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   dmem_q [2**DMEM_AW];
  logic                dmem_we;

  logic [3:0]          opcode;
  logic [RSEL_W-1:0]   rd, rs;
  logic [DATA_W-1:0]   imm;
  logic [DMEM_AW-1:0]  dmem_addr;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic [DATA_W:0]     add_res, sub_res;
  logic [ADDR_W-1:0]   pc_inc;

  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign rd        = ir_q[DATA_W + RSEL_W +: RSEL_W];
  assign rs        = ir_q[DATA_W +: RSEL_W];
  assign imm       = ir_q[DATA_W-1:0];
  assign dmem_addr = imm[DMEM_AW-1:0];

  // Operands come from the registered file, so rd==rs sees the pre-execute value.
  assign rd_val  = regs_q[rd];
  assign rs_val  = regs_q[rs];
  assign add_res = {1'b0, rd_val} + {1'b0, rs_val};
  assign sub_res = {1'b0, rd_val} - {1'b0, rs_val};
  assign pc_inc  = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    dmem_we = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (cs) state_d = StDecode;
      end
      StDecode: begin
        ir_d    = imem_data;
        state_d = StExecute;
      end
      StExecute: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        case (opcode)
          OpNop: ;
          OpLdi: regs_d[rd] = imm;
          OpAdd: begin
            regs_d[rd] = add_res[DATA_W-1:0];
            carry_d    = add_res[DATA_W];
            zero_d     = (add_res[DATA_W-1:0] == '0);
          end
          OpSub: begin
            // Top bit of the widened difference is the unsigned borrow.
            regs_d[rd] = sub_res[DATA_W-1:0];
            carry_d    = sub_res[DATA_W];
            zero_d     = (sub_res[DATA_W-1:0] == '0);
          end
          OpSt:  dmem_we = 1'b1;
          OpLd:  regs_d[rd] = dmem_q[dmem_addr];
          OpJmp: pc_d = imm[ADDR_W-1:0];
          OpJz: begin
            if (zero_q) pc_d = imm[ADDR_W-1:0];
          end
          OpHalt: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      regs_q  <= '{default: '0};
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Data memory has no reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (dmem_we && !reset) dmem_q[dmem_addr] <= rd_val;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_param.sv
// Scoreboard bench for cpu_param: stimulus pushes time-stamped expected architectural state,
// a monitor pops and compares at the stamped cycle.
module tb_cpu_param;

  localparam int INSTR_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                cs;
  logic [3:0]          imem_addr;
  logic [INSTR_W-1:0]  imem_data;
  logic [31:0]         regs_flat;
  logic [3:0]          pc;
  logic                zero_flag, carry_flag, halted;

  logic [INSTR_W-1:0]  imem [16];

  typedef struct packed {
    int          stamp;
    logic [31:0] regs;
    logic [3:0]  pc;
    logic        z;
    logic        c;
    logic        h;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  cpu_param #(
    .DATA_W (8),
    .NREGS  (4),
    .ADDR_W (4),
    .DMEM_AW(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .regs_flat (regs_flat),
    .pc        (pc),
    .zero_flag (zero_flag),
    .carry_flag(carry_flag),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid one cycle after the address.
  always @(posedge clk) imem_data <= imem[imem_addr];
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [INSTR_W-1:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                             input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input string name, input int dly,
                           input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3,
                           input logic [3:0] p, input logic z, input logic c, input logic h);
    exp_t e;
    e.stamp = cyc + dly;
    e.regs  = {r3, r2, r1, r0};
    e.pc    = p;
    e.z     = z;
    e.c     = c;
    e.h     = h;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  // Monitor: compares each expectation at its stamped cycle, away from the clock edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    #2;
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      n_cmp++;
      if (e.stamp != cyc || regs_flat !== e.regs || pc !== e.pc || imem_addr !== e.pc ||
          zero_flag !== e.z || carry_flag !== e.c || halted !== e.h) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got regs=%h pc=%h addr=%h z=%b c=%b h=%b, want regs=%h pc=%h z=%b c=%b h=%b",
                 nm, cyc, regs_flat, pc, imem_addr, zero_flag, carry_flag, halted,
                 e.regs, e.pc, e.z, e.c, e.h);
      end
    end
  end

  initial begin
    reset = 1'b1;
    cs    = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = '0;
    imem[0]  = ins(4'h1, 2'd0, 2'd0, 8'h02);
    imem[1]  = ins(4'h1, 2'd1, 2'd0, 8'h04);
    imem[2]  = ins(4'h2, 2'd0, 2'd1, 8'h00);
    imem[3]  = ins(4'h1, 2'd0, 2'd0, 8'h05);
    imem[4]  = ins(4'h1, 2'd1, 2'd0, 8'h0E);
    imem[5]  = ins(4'h3, 2'd0, 2'd1, 8'h00);
    imem[6]  = ins(4'h1, 2'd2, 2'd0, 8'hFF);
    imem[7]  = ins(4'h1, 2'd3, 2'd0, 8'h01);
    imem[8]  = ins(4'h2, 2'd2, 2'd3, 8'h00);
    imem[9]  = ins(4'h1, 2'd0, 2'd0, 8'hF7);
    imem[10] = ins(4'h4, 2'd0, 2'd0, 8'h06);
    imem[11] = ins(4'h5, 2'd2, 2'd0, 8'h06);

    // Reset for 5 cycles.
    @(negedge clk);
    tick(4);
    expect_at("reset", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1);

    // LDI/LDI/ADD with exact 9-cycle latency.
    expect_at("ldi_pair", 8, 8'h02, 8'h04, 8'h00, 8'h00, 4'h2, 1'b0, 1'b0, 1'b0);
    expect_at("add_basic", 9, 8'h06, 8'h04, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 1'b0);
    cs = 1'b1;
    tick(9);
    cs = 1'b0;

    // Stall with cs low.
    expect_at("cs_hold", 10, 8'h06, 8'h04, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 1'b0);
    tick(10);

    // SUB with borrow, then ADD wrapping to zero.
    expect_at("sub_borrow", 9, 8'hF7, 8'h0E, 8'h00, 8'h00, 4'h6, 1'b0, 1'b1, 1'b0);
    expect_at("add_wrap", 18, 8'hF7, 8'h0E, 8'h00, 8'h01, 4'h9, 1'b1, 1'b1, 1'b0);
    cs = 1'b1;
    tick(18);
    cs = 1'b0;

    // Store/load, flags untouched.
    expect_at("st_ld", 9, 8'hF7, 8'h0E, 8'hF7, 8'h01, 4'hC, 1'b1, 1'b1, 1'b0);
    cs = 1'b1;
    tick(9);
    cs = 1'b0;

    // One-cycle reset, data memory must survive.
    imem[0] = ins(4'h5, 2'd3, 2'd0, 8'h06);
    imem[1] = ins(4'h3, 2'd1, 2'd1, 8'h00);
    imem[2] = ins(4'h7, 2'd0, 2'd0, 8'h0A);
    reset = 1'b1;
    tick(1);
    expect_at("rst_1cyc", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    expect_at("ld_after_rst", 3, 8'h00, 8'h00, 8'h00, 8'hF7, 4'h1, 1'b0, 1'b0, 1'b0);
    cs = 1'b1;
    tick(3);
    cs = 1'b0;

    // SUB R1,R1 -> zero, JZ taken.
    expect_at("jz_taken", 6, 8'h00, 8'h00, 8'h00, 8'hF7, 4'hA, 1'b1, 1'b0, 1'b0);
    cs = 1'b1;
    tick(6);
    cs = 1'b0;

    // zero=0, JZ falls through; ADD rd==rs; HALT.
    imem[10] = ins(4'h1, 2'd0, 2'd0, 8'h03);
    imem[11] = ins(4'h2, 2'd0, 2'd3, 8'h00);
    imem[12] = ins(4'h7, 2'd0, 2'd0, 8'h0A);
    imem[13] = ins(4'h2, 2'd3, 2'd3, 8'h00);
    imem[14] = ins(4'h8, 2'd0, 2'd0, 8'h00);
    expect_at("jz_not_taken", 9, 8'hFA, 8'h00, 8'h00, 8'hF7, 4'hD, 1'b0, 1'b0, 1'b0);
    expect_at("add_rd_eq_rs", 12, 8'hFA, 8'h00, 8'h00, 8'hEE, 4'hE, 1'b0, 1'b1, 1'b0);
    expect_at("halt", 15, 8'hFA, 8'h00, 8'h00, 8'hEE, 4'hE, 1'b0, 1'b1, 1'b1);
    cs = 1'b1;
    tick(15);

    expect_at("halt_hold10", 10, 8'hFA, 8'h00, 8'h00, 8'hEE, 4'hE, 1'b0, 1'b1, 1'b1);
    expect_at("halt_hold20", 20, 8'hFA, 8'h00, 8'h00, 8'hEE, 4'hE, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cs = ~cs;
      tick(1);
    end
    cs = 1'b0;

    // Reset out of HALT, then NOP sled with PC wrap.
    reset = 1'b1;
    tick(1);
    expect_at("rst_from_halt", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = '0;
    imem[5]  = ins(4'h9, 2'd2, 2'd0, 8'h33);
    imem[15] = ins(4'h1, 2'd1, 2'd0, 8'h5A);
    expect_at("pc_at_15", 45, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
    expect_at("pc_wrap", 48, 8'h00, 8'h5A, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    cs = 1'b1;
    tick(48);
    cs = 1'b0;

    // Reset during EXECUTE of LDI R3,0xAA.
    imem[0] = ins(4'h1, 2'd3, 2'd0, 8'hAA);
    cs = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    expect_at("rst_in_exec", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    expect_at("post_rst_mid", 2, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_at("post_rst_ldi", 3, 8'h00, 8'h00, 8'h00, 8'hAA, 4'h1, 1'b0, 1'b0, 1'b0);
    tick(3);
    cs = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register, ALU and data-memory word width.
REQ-002 SHALL have parameter NREGS, default 4, meaning number of general registers (power of two, >=2); RSEL_W = clog2(NREGS).
REQ-003 SHALL have parameter ADDR_W, default 4, meaning PC and instruction-address width.
REQ-004 SHALL have parameter DMEM_AW, default 4, meaning internal data-memory address width (depth 2^DMEM_AW); DMEM_AW <= DATA_W.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port cs, input, 1, meaning run enable; low stalls the core in FETCH.
REQ-008 SHALL have port imem_addr, output, ADDR_W, meaning instruction fetch address (equals PC).
REQ-009 SHALL have port imem_data, input, INSTR_W = 4+2*RSEL_W+DATA_W, meaning instruction word, valid one cycle after imem_addr: [opcode(4) | rd | rs | imm(DATA_W)], MSB first.
REQ-010 SHALL have port regs_flat, output, NREGS*DATA_W, meaning all registers, register i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port pc, output, ADDR_W, meaning program counter.
REQ-012 SHALL have ports zero_flag and carry_flag, output, 1 each, meaning ALU status flags.
REQ-013 SHALL have port halted, output, 1, meaning the core is in HALT.

Function
REQ-014 SHALL implement FSM FETCH -> DECODE -> EXECUTE -> FETCH, plus a terminal HALT state; each non-halting instruction takes exactly 3 cycles.
REQ-015 FETCH SHALL drive imem_addr = pc and advance to DECODE only when cs=1; otherwise it SHALL remain in FETCH with all state held.
REQ-016 DECODE SHALL latch imem_data into the instruction register; cs is ignored in DECODE and EXECUTE, so an instruction in flight always completes.
REQ-017 EXECUTE SHALL perform the opcode and update pc = pc+1 modulo 2^ADDR_W unless a taken jump writes pc.
REQ-018 Opcode 0x0 NOP: no effect beyond the pc increment.
REQ-019 Opcode 0x1 LDI: R[rd] = imm.
REQ-020 Opcode 0x2 ADD: R[rd] = R[rd]+R[rs] truncated to DATA_W; carry_flag = carry out; zero_flag = (result==0).
REQ-021 Opcode 0x3 SUB: R[rd] = R[rd]-R[rs] modulo 2^DATA_W; carry_flag = borrow (R[rd]<R[rs] unsigned); zero_flag = (result==0).
REQ-022 Opcode 0x4 ST: dmem[imm[DMEM_AW-1:0]] = R[rd]. Opcode 0x5 LD: R[rd] = dmem[imm[DMEM_AW-1:0]]. Neither opcode changes the flags.
REQ-023 Opcode 0x6 JMP: pc = imm[ADDR_W-1:0]. Opcode 0x7 JZ: pc = imm[ADDR_W-1:0] if zero_flag=1, else pc+1.
REQ-024 Opcode 0x8 HALT: enter HALT, holding pc at the HALT address; HALT is exited only by reset, and cs has no effect there.
REQ-025 Opcodes 0x9-0xF SHALL execute as NOP.
REQ-026 Flags SHALL change only on ADD and SUB; when rd==rs, ADD and SUB SHALL use the pre-execute register value.
REQ-027 PC SHALL wrap from 2^ADDR_W-1 to 0 with no error indication.

Reset
REQ-028 When reset=1 at a clock edge, the core SHALL enter FETCH and clear pc, all registers, both flags, halted and the instruction register to 0, regardless of current state, including mid-instruction and HALT.
REQ-029 Data memory contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL take priority over cs and over any EXECUTE action in the same cycle.

Verification (defaults DATA_W=8, NREGS=4, ADDR_W=4, DMEM_AW=4)
REQ-031 Apply reset for 5 cycles, then run LDI R0,0x02; LDI R1,0x04; ADD R0,R1 -> R0=0x06, R1=0x04, carry=0, zero=0, pc=3 exactly 9 cycles after cs rises.
REQ-032 Run LDI R0,0x05; LDI R1,0x0E; SUB R0,R1 -> R0=0xF7, carry=1, zero=0. Then run LDI R2,0xFF; LDI R3,0x01; ADD R2,R3 -> R2=0x00, carry=1, zero=1.
REQ-033 Run LDI R0,0xF7; ST R0,0x06; LD R2,0x06 -> R2=0xF7. Then assert reset for 1 cycle and run LD R3,0x06 -> R3=0xF7, confirming data memory survives reset.
REQ-034 Run SUB R1,R1 (zero=1), then JZ 0x0A -> pc=0x0A. Run a zero=0 case, then JZ 0x0A -> pc = old pc+1. Then HALT -> halted=1, pc frozen for 20 cycles while cs toggles.
REQ-035 Hold cs=0 for 10 cycles between instructions -> no register or pc change. Fill imem with NOPs from address 0 and run 16 instructions -> pc wraps 0xF -> 0x0.
REQ-036 Assert reset in the EXECUTE cycle of LDI R3,0xAA -> R3=0x00, pc=0, state FETCH on the next cycle.
